pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline. It sequences data-memory accesses issued from the MEM stage over a req/gnt/rvalid handshake and freezes the EX/MEM register and all upstream registers until each access completes. It also detects load-use hazards, which insert a bubble into ID/EX, and taken branches resolved in EX, which flush IF/ID and ID/EX. It drives the hold and flush inputs of pc_reg, reg_if_id, reg_id_ex and reg_ex_mem.

Parameters:
- TIMEOUT, 16: maximum cycles spent in REQ+RESP before the access is abandoned with an error.
- CNT_W, $clog2(TIMEOUT+1): width of the timeout counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- ex_rd  in  5  rd of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch/jump taken, resolved in EX.
- me_mem_read  in  1  instruction in MEM is a load.
- me_mem_write  in  1  instruction in MEM is a store.
- dmem_gnt  in  1  memory accepted the request.
- dmem_rvalid  in  1  load data valid.
- dmem_req  out  1  request to data memory.
- pc_hold  out  1  PC keeps its value.
- if_id_hold  out  1  IF/ID register keeps its value.
- id_ex_hold  out  1  ID/EX register keeps its value.
- ex_me_hold  out  1  EX/MEM register keeps its value.
- if_id_flush  out  1  IF/ID register loads a NOP.
- id_ex_flush  out  1  ID/EX register loads a bubble.
- mem_err  out  1  one-cycle pulse on access timeout.

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE. Encoding lives in the shared package.
- IDLE:
  - If me_mem_read or me_mem_write is set, go to REQ.
  - The hold is already asserted in this cycle.
- REQ:
  - dmem_req=1, held stable until dmem_gnt.
  - On gnt for a store, go to DONE.
  - On gnt for a load, go to RESP.
- RESP:
  - Wait for dmem_rvalid, then go to DONE.
- DONE:
  - Lasts exactly 1 cycle, then returns to IDLE.
  - All memory holds are released, so the EX/MEM register advances.
  - The next MEM instruction is evaluated in the following IDLE cycle.
- Memory stall: mem_stall = (IDLE & (me_mem_read | me_mem_write)) | REQ | RESP.
  - While mem_stall is set: pc_hold, if_id_hold, id_ex_hold and ex_me_hold are all 1.
  - While mem_stall is set, both flushes are 0. A pending branch or load-use is re-evaluated after release, because EX and ID are held.
- Minimum MEM-stage occupancy:
  - Store: 3 cycles (IDLE, REQ with gnt, DONE).
  - Load: 4 cycles (IDLE, REQ, RESP with rvalid, DONE).
- dmem_gnt and dmem_rvalid asserted in the same cycle while in REQ: the gnt is taken and the state goes to RESP. The rvalid is ignored; memory must not return data before the cycle after gnt.
- Timeout:
  - cnt clears on entry to REQ and increments each cycle in REQ/RESP.
  - When cnt==TIMEOUT-1 and the awaited signal is absent, go to DONE and set mem_err=1 (registered, one cycle).
  - A completion arriving in that same cycle wins; mem_err stays 0.
- Load-use hazard (only when mem_stall=0):
  - Condition: ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Response: pc_hold=1, if_id_hold=1, id_ex_flush=1, ex_me_hold=0.
- Taken branch (only when mem_stall=0): if_id_flush=1, id_ex_flush=1, pc_hold=0.
  - Overrides load-use: the ID instruction is discarded, so PC and IF/ID are not held.
- Output logic: holds and flushes are combinational from state and inputs. dmem_req is decoded from state REQ.
- Reset (rst=1 at a clock edge, including mid-access):
  - state=IDLE, cnt=0, mem_err=0.
  - While rst=1, all outputs are forced to 0.
  - An abandoned access is not resumed.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - the FSM state typedef (IDLE/REQ/RESP/DONE);
  - the x0 register index constant;
  - the default TIMEOUT value.
- One natural sub-module: mem_access_fsm, containing the FSM, timeout counter and mem_err. It outputs mem_stall and dmem_req.
- The top level adds the combinational load-use and branch priority logic.

Test Plan:
- Store in MEM, gnt on the 2nd REQ cycle: dmem_req high for 2 cycles; ex_me_hold high for 3 cycles total; DONE releases; mem_err=0.
- Load in MEM, gnt immediate, rvalid 3 cycles later: states IDLE→REQ→RESP(x3)→DONE; all holds high for 5 cycles, low in DONE.
- ex_mem_read=1, ex_rd=5, id_rs2=5, no MEM access: pc_hold=1, if_id_hold=1, id_ex_flush=1, ex_me_hold=0. Repeat with ex_rd=0: no stall.
- ex_branch_taken=1 together with a load-use condition: if_id_flush=1, id_ex_flush=1, pc_hold=0. Repeat with a concurrent MEM load stall: no flush until DONE, then flush.
- TIMEOUT=4, load with no gnt: dmem_req high 4 cycles; mem_err pulses 1 cycle; DONE follows; return to IDLE.
- rst asserted during RESP: next cycle state=IDLE, dmem_req=0, all holds=0; a fresh access after reset completes normally.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline control slice: memory-access FSM
// states, the x0 register index and the default access timeout.
package rv_pipe_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } mem_state_t;

   localparam logic [4:0]  X0_IDX      = 5'd0;
   localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_access_fsm.sv
// Sequences one MEM-stage data access over req/gnt/rvalid, with a timeout
// that abandons the access and pulses mem_err.
module mem_access_fsm
   import rv_pipe_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT,
   parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic me_mem_read,
   input  logic me_mem_write,
   input  logic dmem_gnt,
   input  logic dmem_rvalid,
   output logic dmem_req,
   output logic mem_stall,
   output logic mem_err
);

   mem_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             is_load;
   logic             err_q;
   logic             at_limit;

   assign at_limit = (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         is_load <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            IDLE: begin
               if (me_mem_read || me_mem_write) begin
                  state   <= REQ;
                  cnt     <= '0;
                  is_load <= me_mem_read;
               end
            end
            REQ: begin
               cnt <= cnt + 1'b1;
               // A same-cycle rvalid is ignored: data may only follow the grant.
               if (dmem_gnt) begin
                  state <= is_load ? RESP : DONE;
               end else if (at_limit) begin
                  state <= DONE;
                  err_q <= 1'b1;
               end
            end
            RESP: begin
               cnt <= cnt + 1'b1;
               if (dmem_rvalid) begin
                  state <= DONE;
               end else if (at_limit) begin
                  state <= DONE;
                  err_q <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign dmem_req  = !rst && (state == REQ);
   assign mem_err   = !rst && err_q;
   assign mem_stall = !rst && (((state == IDLE) && (me_mem_read || me_mem_write)) ||
                               (state == REQ) || (state == RESP));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: memory stalls freeze everything up to
// EX/MEM; otherwise a taken branch flushes, else a load-use inserts a bubble.
module pipe_hazard_ctrl
   import rv_pipe_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT,
   parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   input  logic       ex_branch_taken,
   input  logic       me_mem_read,
   input  logic       me_mem_write,
   input  logic       dmem_gnt,
   input  logic       dmem_rvalid,
   output logic       dmem_req,
   output logic       pc_hold,
   output logic       if_id_hold,
   output logic       id_ex_hold,
   output logic       ex_me_hold,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       mem_err
);

   logic mem_stall;
   logic load_use;
   logic branch;

   mem_access_fsm #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_mem_fsm (
      .clk          (clk),
      .rst          (rst),
      .me_mem_read  (me_mem_read),
      .me_mem_write (me_mem_write),
      .dmem_gnt     (dmem_gnt),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_req     (dmem_req),
      .mem_stall    (mem_stall),
      .mem_err      (mem_err)
   );

   // EX and ID are frozen under a memory stall, so both hazards are simply
   // re-evaluated once the stall releases.
   assign branch   = !rst && !mem_stall && ex_branch_taken;
   assign load_use = !rst && !mem_stall && ex_mem_read && (ex_rd != X0_IDX) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   assign pc_hold     = mem_stall || (load_use && !branch);
   assign if_id_hold  = mem_stall || (load_use && !branch);
   assign id_ex_hold  = mem_stall;
   assign ex_me_hold  = mem_stall;
   assign if_id_flush = branch;
   assign id_ex_flush = branch || load_use;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl: a default-timeout instance and a
// TIMEOUT=4 instance share stimulus; expected output vectors go through a queue.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       ex_mem_read, ex_branch_taken, me_mem_read, me_mem_write;
   logic       dmem_gnt, dmem_rvalid;

   logic a_req, a_pch, a_ifh, a_idh, a_exh, a_iff, a_idf, a_err;
   logic b_req, b_pch, b_ifh, b_idh, b_exh, b_iff, b_idf, b_err;
   logic [7:0] obs_a, obs_b;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs1, rs2, exrd;
      logic       exld, br, mrd, mwr, gnt, rv;
   } stim_t;

   logic [7:0] exp_q[$];

   // bit order: req, pc_hold, if_id_hold, id_ex_hold, ex_me_hold, if_id_flush, id_ex_flush, mem_err
   localparam logic [7:0] Z    = 8'b0000_0000;
   localparam logic [7:0] STL  = 8'b0111_1000;
   localparam logic [7:0] STLR = 8'b1111_1000;
   localparam logic [7:0] LU   = 8'b0110_0010;
   localparam logic [7:0] BR   = 8'b0000_0110;
   localparam logic [7:0] ERR  = 8'b0000_0001;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_req(a_req),
      .pc_hold(a_pch), .if_id_hold(a_ifh), .id_ex_hold(a_idh), .ex_me_hold(a_exh),
      .if_id_flush(a_iff), .id_ex_flush(a_idf), .mem_err(a_err)
   );

   pipe_hazard_ctrl #(.TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_req(b_req),
      .pc_hold(b_pch), .if_id_hold(b_ifh), .id_ex_hold(b_idh), .ex_me_hold(b_exh),
      .if_id_flush(b_iff), .id_ex_flush(b_idf), .mem_err(b_err)
   );

   assign obs_a = {a_req, a_pch, a_ifh, a_idh, a_exh, a_iff, a_idf, a_err};
   assign obs_b = {b_req, b_pch, b_ifh, b_idh, b_exh, b_iff, b_idf, b_err};

   function automatic stim_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] exrd,
                                logic exld, logic br, logic mrd, logic mwr, logic gnt, logic rv);
      stim_t s;
      s = '{r, rs1, rs2, exrd, exld, br, mrd, mwr, gnt, rv};
      return s;
   endfunction

   task automatic drive(input stim_t s);
      rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.exrd;
      ex_mem_read = s.exld; ex_branch_taken = s.br;
      me_mem_read = s.mrd; me_mem_write = s.mwr; dmem_gnt = s.gnt; dmem_rvalid = s.rv;
   endtask

   task automatic test_reset();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      s.push_back(mk(1, 5, 0, 5, 1, 1, 1, 0, 1, 1)); e.push_back(Z);
      s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(Z);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(Z);
      foreach (s[i]) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         exp = exp_q.pop_front();
         vectors += 2;
         if (obs_a !== exp) begin miscompares++; $display("FAIL reset[%0d] dut_a got=%b exp=%b", i, obs_a, exp); end
         if (obs_b !== exp) begin miscompares++; $display("FAIL reset[%0d] dut_b got=%b exp=%b", i, obs_b, exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(STL);   // IDLE
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(STLR);  // REQ
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(STLR);  // REQ+gnt
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(Z);     // DONE
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(Z);
      foreach (s[i]) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         exp = exp_q.pop_front();
         vectors += 2;
         if (obs_a !== exp) begin miscompares++; $display("FAIL store[%0d] dut_a got=%b exp=%b", i, obs_a, exp); end
         if (obs_b !== exp) begin miscompares++; $display("FAIL store[%0d] dut_b got=%b exp=%b", i, obs_b, exp); end
         @(posedge clk); #1;
      end
   endtask

   // For dut_b (TIMEOUT=4) the rvalid lands on the final counted cycle: completion wins.
   task automatic test_load();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(STL);   // IDLE
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0)); e.push_back(STLR);  // REQ+gnt
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(STL);   // RESP
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(STL);   // RESP
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1)); e.push_back(STL);   // RESP+rvalid
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(Z);     // DONE
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(Z);
      foreach (s[i]) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         exp = exp_q.pop_front();
         vectors += 2;
         if (obs_a !== exp) begin miscompares++; $display("FAIL load[%0d] dut_a got=%b exp=%b", i, obs_a, exp); end
         if (obs_b !== exp) begin miscompares++; $display("FAIL load[%0d] dut_b got=%b exp=%b", i, obs_b, exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      s.push_back(mk(0, 0, 5, 5, 1, 0, 0, 0, 0, 0)); e.push_back(LU);
      s.push_back(mk(0, 7, 3, 7, 1, 0, 0, 0, 0, 0)); e.push_back(LU);
      s.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); e.push_back(Z);   // rd = x0
      s.push_back(mk(0, 5, 5, 5, 0, 0, 0, 0, 0, 0)); e.push_back(Z);   // not a load
      s.push_back(mk(0, 4, 6, 5, 1, 0, 0, 0, 0, 0)); e.push_back(Z);   // no match
      foreach (s[i]) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         exp = exp_q.pop_front();
         vectors++;
         if (obs_a !== exp) begin miscompares++; $display("FAIL load_use[%0d] got=%b exp=%b", i, obs_a, exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      s.push_back(mk(0, 0, 5, 5, 1, 1, 0, 0, 0, 0)); e.push_back(BR);
      s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); e.push_back(BR);
      s.push_back(mk(0, 0, 5, 5, 1, 1, 1, 0, 0, 0)); e.push_back(STL);   // IDLE with load
      s.push_back(mk(0, 0, 5, 5, 1, 1, 1, 0, 1, 0)); e.push_back(STLR);  // REQ+gnt
      s.push_back(mk(0, 0, 5, 5, 1, 1, 1, 0, 0, 1)); e.push_back(STL);   // RESP+rvalid
      s.push_back(mk(0, 0, 5, 5, 1, 1, 1, 0, 0, 0)); e.push_back(BR);    // DONE: flush now
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(Z);
      foreach (s[i]) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         exp = exp_q.pop_front();
         vectors++;
         if (obs_a !== exp) begin miscompares++; $display("FAIL branch[%0d] got=%b exp=%b", i, obs_a, exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(STL);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1)); e.push_back(STLR);  // gnt+rvalid: rvalid ignored
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(STL);   // still RESP
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1)); e.push_back(STL);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(Z);     // DONE
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(STL);   // next: store
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(STLR);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(Z);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(Z);
      foreach (s[i]) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         exp = exp_q.pop_front();
         vectors += 2;
         if (obs_a !== exp) begin miscompares++; $display("FAIL b2b[%0d] dut_a got=%b exp=%b", i, obs_a, exp); end
         if (obs_b !== exp) begin miscompares++; $display("FAIL b2b[%0d] dut_b got=%b exp=%b", i, obs_b, exp); end
         @(posedge clk); #1;
      end
   endtask

   // Only dut_b is checked; the trailing reset resynchronises dut_a.
   task automatic test_timeout();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(STL);
      for (int unsigned k = 0; k < 4; k++) begin
         s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(STLR);
      end
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(ERR);   // DONE + mem_err
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(Z);     // IDLE, pulse gone
      s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(Z);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(Z);
      foreach (s[i]) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         exp = exp_q.pop_front();
         vectors++;
         if (obs_b !== exp) begin miscompares++; $display("FAIL timeout[%0d] got=%b exp=%b", i, obs_b, exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      stim_t s[$];
      logic [7:0] e[$];
      logic [7:0] exp;
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(STL);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0)); e.push_back(STLR);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(STL);   // RESP
      s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0)); e.push_back(Z);     // rst in RESP
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); e.push_back(Z);     // not resumed
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(STL);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0)); e.push_back(STLR);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); e.push_back(Z);
      s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(Z);
      foreach (s[i]) begin
         drive(s[i]); exp_q.push_back(e[i]);
         @(negedge clk);
         exp = exp_q.pop_front();
         vectors += 2;
         if (obs_a !== exp) begin miscompares++; $display("FAIL reset_mid[%0d] dut_a got=%b exp=%b", i, obs_a, exp); end
         if (obs_b !== exp) begin miscompares++; $display("FAIL reset_mid[%0d] dut_b got=%b exp=%b", i, obs_b, exp); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); #1;
      test_reset();
      test_store();
      test_load();
      test_load_use();
      test_branch();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
